// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory, redirect and decode signals of the fetch stage
interface fetch_stage_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic [24:0] dec_imm_field;
  modport master (
    output imem_req_valid, imem_addr, dec_valid, dec_instr, dec_pc, dec_imm_field,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, dec_ready
  );
  modport slave (
    input  imem_req_valid, imem_addr, dec_valid, dec_instr, dec_pc, dec_imm_field,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, dec_ready
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: PC owner issuing word fetches into a 2-entry in-order decode queue with redirect flush
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_1000
) (
  input logic clk,
  input logic reset,
  fetch_stage_if.master bus
);
  logic [31:0] pc_q, pc_d;
  logic [2:0]  outstanding_q, outstanding_d, drop_cnt_q, drop_cnt_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] tag_q [2];
  logic [31:0] tag_d [2];
  logic        tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;
  logic [63:0] ent_q [2];
  logic [63:0] ent_d [2];
  logic [63:0] new_ent;
  logic [2:0]  credit;
  logic        redir, rsp, live_rsp, issue, push, pop, shift, wr0, wr1;
  assign redir    = bus.redirect_valid;
  assign rsp      = bus.imem_rsp_valid;
  assign live_rsp = rsp && drop_cnt_q == 3'd0;
  assign credit   = {1'b0, count_q} + outstanding_q - drop_cnt_q;
  assign bus.imem_req_valid = !reset && !redir && credit < 3'd2;
  assign bus.imem_addr      = pc_q;
  assign bus.dec_valid      = count_q != 2'd0;
  assign bus.dec_instr      = ent_q[0][63:32];
  assign bus.dec_pc         = ent_q[0][31:0];
  assign bus.dec_imm_field  = ent_q[0][63:39];
  assign issue   = bus.imem_req_valid && bus.imem_req_ready;
  assign push    = live_rsp && !redir;
  assign pop     = bus.dec_valid && bus.dec_ready && !redir;
  assign new_ent = {bus.imem_rsp_data, tag_q[tag_rd_q]};
  // Slot 0 is always the head; it keeps its last contents when the queue drains.
  assign shift = pop && count_q == 2'd2;
  assign wr0   = push && (count_q == 2'd0 || (count_q == 2'd1 && pop));
  assign wr1   = push && ((count_q == 2'd1 && !pop) || (count_q == 2'd2 && pop));
  always_comb begin
    pc_d          = redir ? bus.redirect_pc : issue ? pc_q + 32'd4 : pc_q;
    outstanding_d = outstanding_q + {2'b0, issue} - {2'b0, rsp};
    drop_cnt_d    = redir ? outstanding_q - {2'b0, rsp} : (rsp && drop_cnt_q != 3'd0) ? drop_cnt_q - 3'd1 : drop_cnt_q;
    tag_d[0]      = (issue && !tag_wr_q) ? pc_q : tag_q[0];
    tag_d[1]      = (issue && tag_wr_q) ? pc_q : tag_q[1];
    tag_wr_d      = redir ? 1'b0 : tag_wr_q ^ issue;
    tag_rd_d      = redir ? 1'b0 : tag_rd_q ^ live_rsp;
    count_d       = redir ? 2'd0 : count_q + {1'b0, push} - {1'b0, pop};
    ent_d[0]      = wr0 ? new_ent : shift ? ent_q[1] : ent_q[0];
    ent_d[1]      = wr1 ? new_ent : ent_q[1];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      count_q       <= '0;
      tag_rd_q      <= 1'b0;
      tag_wr_q      <= 1'b0;
      tag_q         <= '{default: '0};
      ent_q         <= '{default: '0};
    end else begin
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      count_q       <= count_d;
      tag_rd_q      <= tag_rd_d;
      tag_wr_q      <= tag_wr_d;
      tag_q         <= tag_d;
      ent_q         <= ent_d;
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized fetch-stage bench with an architectural-stream scoreboard
module tb_fetch_stage;
  localparam logic [31:0] RP = 32'h0000_1000;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  fetch_stage_if bus ();
  fetch_stage #(.RESET_PC(RP)) dut (.clk(clk), .reset(reset), .bus(bus));
  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;
  req_t        pend[$];
  logic [31:0] exp_q[$];
  int checks = 0, failures = 0, pops = 0, cyc = 0, last_due = 0;
  int lat_max = 1, rdy_pct = 100;
  logic        prev_reset = 1'b0, prev_redir = 1'b0, last_rv = 1'b0;
  logic [31:0] prev_rpc = '0;
  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  always @(posedge clk) cyc <= cyc + 1;
  // One stimulus cycle: decode/redirect/reset inputs plus the memory's ready and in-order response.
  task automatic drive(input logic dr, input logic rv, input logic [31:0] rpc, input logic rst);
    @(posedge clk);
    #1;
    reset              = rst;
    bus.dec_ready      = dr;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.imem_req_ready = $urandom_range(99) < rdy_pct;
    bus.imem_rsp_valid = pend.size() > 0 && pend[0].due <= cyc;
    bus.imem_rsp_data  = $urandom;
    if (bus.imem_rsp_valid) bus.imem_rsp_data = mem(pend[0].addr);
    if (rst || rv) begin
      exp_q.delete();
      exp_q.push_back(rst ? RP : rpc);
    end
    last_rv = rv;
  endtask
  always @(negedge clk) begin
    logic [31:0] e, w;
    int lat, due;
    if (reset) begin
      chk("req_valid_in_reset", {31'b0, bus.imem_req_valid}, 32'd0);
      pend.delete();
      last_due = 0;
    end else begin
      if (prev_reset) begin
        chk("rst_dec_valid", {31'b0, bus.dec_valid}, 32'd0);
        chk("rst_dec_instr", bus.dec_instr, 32'd0);
        chk("rst_dec_pc", bus.dec_pc, 32'd0);
        chk("rst_dec_imm", {7'b0, bus.dec_imm_field}, 32'd0);
        chk("rst_imem_addr", bus.imem_addr, RP);
        if (!bus.redirect_valid) chk("first_req_after_reset", {31'b0, bus.imem_req_valid}, 32'd1);
      end
      if (prev_redir && !bus.redirect_valid) begin
        chk("redir_req_valid", {31'b0, bus.imem_req_valid}, 32'd1);
        chk("redir_req_addr", bus.imem_addr, prev_rpc);
      end
      if (bus.redirect_valid) chk("req_during_redirect", {31'b0, bus.imem_req_valid}, 32'd0);
      else if (bus.dec_valid && bus.dec_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_empty: dec_pc %h presented with nothing expected", bus.dec_pc);
        end else begin
          e = exp_q.pop_front();
          w = mem(e);
          chk("dec_pc", bus.dec_pc, e);
          chk("dec_instr", bus.dec_instr, w);
          chk("dec_imm_field", {7'b0, bus.dec_imm_field}, {7'b0, w[31:7]});
          exp_q.push_back(e + 32'd4);
          pops++;
        end
      end
      if (bus.imem_rsp_valid && pend.size() > 0) void'(pend.pop_front());
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        lat = $urandom_range(lat_max, 1);
        due = (cyc + lat > last_due) ? cyc + lat : last_due;
        pend.push_back('{addr: bus.imem_addr, due: due});
        last_due = due;
      end
    end
    prev_reset = reset;
    prev_redir = bus.redirect_valid;
    prev_rpc   = bus.redirect_pc;
  end
  initial begin
    logic rv, rs;
    logic [31:0] tgt;
    reset = 1'b1;
    bus.dec_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data = '0;
    repeat (3) drive(1'b0, 1'b0, '0, 1'b1);
    repeat (30) drive(1'b1, 1'b0, '0, 1'b0);
    repeat (12) drive(1'b0, 1'b0, '0, 1'b0);
    @(negedge clk);
    chk("stall_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
    chk("stall_dec_valid", {31'b0, bus.dec_valid}, 32'd1);
    repeat (10) drive(1'b1, 1'b0, '0, 1'b0);
    lat_max = 3;
    repeat (6) drive(1'b1, 1'b0, '0, 1'b0);
    drive(1'b1, 1'b1, 32'h0000_2000, 1'b0);
    repeat (20) drive(1'b1, 1'b0, '0, 1'b0);
    lat_max = 4;
    rdy_pct = 75;
    repeat (3000) begin
      rs  = $urandom_range(999) < 3;
      rv  = !rs && !last_rv && $urandom_range(99) < 5;
      tgt = ($urandom_range(9) == 0) ? 32'hFFFF_FFF0 : 32'h0000_2000 + 32'($urandom_range(1023)) * 32'd4;
      drive($urandom_range(99) < 70, rv, tgt, rs);
    end
    rdy_pct = 100;
    lat_max = 2;
    repeat (10) drive(1'b0, 1'b0, '0, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b1);
    repeat (10) drive(1'b1, 1'b0, '0, 1'b0);
    @(negedge clk);
    checks++;
    if (pops < 200) begin
      failures++;
      $display("FAIL progress: %0d instructions decoded, need at least 200", pops);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
